// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory
// waits (with a timeout watchdog), and counts stall cycles for perf monitoring.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_wb_bubble,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       err_nxt;
    logic       load_use;
    logic       freeze;
    logic       apply_hazard;

    // A load in EX whose destination feeds the ID instruction; r0 never hazards.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    // State register, wait counter and sticky watchdog flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= RUN;
            wait_cnt        <= 8'd0;
            mem_timeout_err <= 1'b0;
        end else begin
            state           <= state_nxt;
            wait_cnt        <= wait_cnt_nxt;
            mem_timeout_err <= err_nxt;
        end
    end

    // Next-state logic: pick which control regime applies this cycle.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = mem_timeout_err;
        freeze       = 1'b0;
        apply_hazard = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze       = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end else begin
                    apply_hazard = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    apply_hazard = 1'b1;
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    freeze       = 1'b1;
                    wait_cnt_nxt = wait_cnt + 8'd1;
                    // Counter holds the number of MEM_WAIT cycles entered so far.
                    if (wait_cnt == TIMEOUT) begin
                        state_nxt = ERROR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Pipeline control outputs; reset overrides everything combinationally.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        if (reset) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_en      = 1'b0;
            id_ex_flush   = 1'b1;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (state == ERROR) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (freeze) begin
            // Hold the front of the pipe; WB still clocks but retires nothing,
            // so the frozen MEM instruction is not written back twice.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (apply_hazard) begin
            if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                // A taken branch discards the held IF/ID instruction anyway.
                if_id_flush = ex_branch_taken;
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 6;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs, id_rt, ex_rd;
    logic          id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic          ex_mem_en, mem_wb_en, mem_wb_bubble, mem_timeout_err;
    logic [CW-1:0] stall_cnt;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .mem_wb_bubble(mem_wb_bubble),
        .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_bubble}
    wire [7:0] ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                       ex_mem_en, mem_wb_en, mem_wb_bubble};

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = running, 1 = waiting on memory, 2 = dead after timeout.
    int m_mode  = 0;
    int m_waits = 0;   // MEM_WAIT cycles spent in the current wait
    int m_stall = 0;
    int m_err   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_ctrl();
        logic lu;
        logic frz;
        if (reset) return 8'b0010_1001;
        if (m_mode == 2) return 8'b0000_0001;
        frz = (m_mode == 0) ? (mem_req && !mem_ready) : !mem_ready;
        if (frz) return 8'b0000_0011;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        if (lu) return {2'b00, ex_branch_taken, 5'b1_1110};
        if (ex_branch_taken) return 8'b1111_1110;
        return 8'b1101_0110;
    endfunction

    // Apply one cycle of inputs, check combinational controls, clock, check state.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mrd, input logic [4:0] rd, input logic br,
                        input logic req, input logic rdy);
        logic [7:0] e;
        id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mrd;
        ex_rd = rd; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
        #1;
        e = exp_ctrl();
        chk("ctrl", {24'd0, ctrl}, {24'd0, e});
        // Advance the model using this cycle's values.
        if (e[7] == 1'b0 && m_stall < SAT) m_stall++;
        if (m_mode == 0) begin
            if (req && !rdy) begin m_mode = 1; m_waits = 0; end
        end else if (m_mode == 1) begin
            if (rdy) m_mode = 0;
            else begin
                m_waits++;
                if (m_waits == TMO) begin m_mode = 2; m_err = 1; end
            end
        end
        @(posedge clk);
        #1;
        chk("stall_cnt", {26'd0, stall_cnt}, m_stall);
        chk("timeout_err", {31'd0, mem_timeout_err}, m_err);
    endtask

    task automatic idle();
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_ctrl", {24'd0, ctrl}, 32'h29);
        chk("rst_cnt", {26'd0, stall_cnt}, 0);
        chk("rst_err", {31'd0, mem_timeout_err}, 0);
        m_mode = 0; m_waits = 0; m_stall = 0; m_err = 0;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0;
        ex_rd = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Load-use on rs, then cases that must not stall.
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        // Branch flush alone and with a simultaneous load-use.
        step(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        step(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        // mem_ready without mem_req is ignored.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Memory wait: three freeze cycles, released on the fourth.
        do_reset();
        repeat (3) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        idle();

        // Timeout into ERROR, late mem_ready ignored, counter saturates.
        do_reset();
        repeat (TMO + 2) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (3) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        repeat (SAT + 5) idle();
        do_reset();
        idle();

        // Reset pulse in the middle of a memory wait.
        repeat (2) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        do_reset();
        idle();
        step(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the enable and flush/bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three conditions:
- load-use hazards;
- taken-branch flushes resolved in EX;
- a multi-cycle data-memory handshake in MEM, with a timeout watchdog.

It also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
MEM_TIMEOUT, 15, maximum consecutive MEM_WAIT cycles before entering ERROR (range 1..255)
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  destination register of the instruction in EX
ex_branch_taken  in  1  branch in EX resolved taken this cycle
mem_req  in  1  instruction in MEM accesses data memory
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_en  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX loads a bubble (all control bits 0)
ex_mem_en  out  1  EX/MEM load enable
mem_wb_en  out  1  MEM/WB load enable
mem_wb_bubble  out  1  MEM/WB loads with reg_write and mem_to_reg forced 0
mem_timeout_err  out  1  sticky watchdog error flag
stall_cnt  out  CNT_W  count of cycles with pc_en=0

Behaviour:
- States: RUN, MEM_WAIT, ERROR. State, wait counter (8 bit), mem_timeout_err and stall_cnt are registers on posedge clk.
- Asynchronous reset:
  - State goes to RUN; wait counter, stall_cnt and mem_timeout_err go to 0.
  - While reset is high, all *_en outputs are 0 and if_id_flush, id_ex_flush and mem_wb_bubble are 1.
- Control outputs are combinational from state and inputs (same-cycle response). Default: all *_en = 1, all flush/bubble = 0.
- load_use = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
- RUN, evaluated in priority order:
  1. mem_req & !mem_ready:
     - pc_en, if_id_en, id_ex_en, ex_mem_en = 0 (freeze).
     - mem_wb_en = 1 with mem_wb_bubble = 1, so WB does not retire a duplicate write.
     - Next state MEM_WAIT; wait counter := 1.
  2. Else if load_use:
     - pc_en = 0, if_id_en = 0, id_ex_flush = 1; EX/MEM and MEM/WB advance.
     - If ex_branch_taken is also 1, if_id_flush = 1 as well; the branch wins over the held IF/ID.
  3. Else if ex_branch_taken: if_id_flush = 1, id_ex_flush = 1, all enables 1.
  4. Else: defaults.
- MEM_WAIT:
  - If mem_ready = 1: outputs are exactly as RUN rules 2–4 (memory condition satisfied); next state RUN; wait counter := 0.
  - Else: freeze outputs as in rule 1; wait counter += 1. If the wait counter equals MEM_TIMEOUT, next state ERROR and mem_timeout_err := 1.
- ERROR: all *_en = 0, mem_wb_bubble = 1. The state is held until reset; mem_timeout_err stays 1 until reset.
- stall_cnt: +1 on every clock edge where pc_en = 0 (outside reset); saturates at 2^CNT_W−1, no wrap.
- ex_rd = 0 never causes a load-use stall.
- mem_ready asserted while mem_req = 0 is ignored.
- Reset asserted mid-MEM_WAIT aborts immediately to RUN.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5 for 1 cycle → pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1; stall_cnt 0→1.
- No false stall: ex_mem_read=1, ex_rd=0, id_rs=0 → defaults. ex_rd=7, id_rt=7, id_uses_rt=0 → no stall.
- Branch flush: ex_branch_taken=1 with no hazard → if_id_flush=1, id_ex_flush=1, pc_en=1; simultaneous load_use → pc_en=0, if_id_flush=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 → 3 freeze cycles with mem_wb_bubble=1, release on cycle 4, state back in RUN, stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready never asserted → ERROR after 4 cycles, mem_timeout_err=1 held; a later mem_ready=1 has no effect; reset clears it to 0.
- Async reset mid-MEM_WAIT: reset pulse between clock edges → outputs immediately forced (enables 0, flushes 1), stall_cnt=0, state RUN after release.
